wave_collision_engine: RTL

- Frame-sequenced collision engine for the invader wave.
- Scans the NUM_ROWS x NUM_COLS invader grid one cell per clock against up to NUM_BULLETS player projectiles in parallel.
- Maintains the alive map, per-frame score and kill count, the defeat-line check and the wave-cleared flag.
- Sits between the projectile controllers / invader movement logic and the game-state FSM / score display. Triggered once per frame by frame_start.

---
 rtl/wave_collision_engine.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/wave_collision_engine.sv
// Frame-sequenced invader collision engine: scans the grid one cell per clock
// against a snapshot of all projectiles, then runs the defeat-line and wave-clear checks.
module wave_collision_engine #(
  parameter int NUM_COLS    = 10,
  parameter int NUM_ROWS    = 3,
  parameter int NUM_BULLETS = 2,
  parameter int ROW_PITCH   = 100,
  parameter int INV_W       = 64,
  parameter int INV_H       = 32,
  parameter int PROJ_W      = 16,
  parameter int PROJ_H      = 32,
  parameter int DEFEAT_Y    = 568,
  parameter int ROW_POINTS  = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic                                 revive,
  input  logic [NUM_BULLETS-1:0]               bullet_active,
  input  logic [NUM_BULLETS-1:0][11:0]         proj_x,
  input  logic [NUM_BULLETS-1:0][11:0]         proj_y,
  input  logic [NUM_COLS-1:0][11:0]            inv_x,
  input  logic [9:0]                           enemy_ypos,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]    alive,
  output logic                                 busy,
  output logic                                 scan_done,
  output logic [NUM_BULLETS-1:0]               bullet_hit,
  output logic [15:0]                          frame_score,
  output logic [7:0]                           kill_count,
  output logic                                 player_hit,
  output logic                                 all_dead
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, CHECK, DONE} state_t;
  state_t state_reg, state_next;

  logic [NUM_ROWS-1:0][NUM_COLS-1:0] alive_reg;
  logic [NUM_BULLETS-1:0][11:0]      px_reg, py_reg;
  logic [NUM_BULLETS-1:0]            act_reg, hit_reg;
  logic [NUM_COLS-1:0][11:0]         ix_reg;
  logic [9:0]                        ey_reg;
  logic [RW-1:0]                     row_reg;
  logic [CW-1:0]                     col_reg;
  logic [15:0]                       score_reg;
  logic [7:0]                        kill_reg;
  logic                              player_hit_reg, all_dead_reg;

  logic [12:0]            cell_x, cell_y;
  logic [NUM_BULLETS-1:0] overlap, win;
  logic                   any_overlap, kill, last_cell;
  logic [15:0]            points;
  logic                   low_found;
  logic [RW-1:0]          low_row;
  logic [12:0]            bottom_y;

  assign cell_x    = {1'b0, ix_reg[col_reg]};
  assign cell_y    = 13'(ey_reg) + 13'(row_reg) * 13'(ROW_PITCH);
  assign last_cell = (row_reg == RW'(NUM_ROWS - 1)) && (col_reg == CW'(NUM_COLS - 1));
  assign points    = (16'(NUM_ROWS) - 16'(row_reg)) * 16'(ROW_POINTS);

  // hit_reg doubles as the consumed mask: a channel that already scored is out.
  generate
    for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_overlap
      logic [12:0] px, py;
      assign px = {1'b0, px_reg[gi]};
      assign py = {1'b0, py_reg[gi]};
      assign overlap[gi] = act_reg[gi] && !hit_reg[gi] &&
                           (px <= cell_x + 13'(INV_W)) && (px + 13'(PROJ_W) >= cell_x) &&
                           (py <= cell_y + 13'(INV_H)) && (py + 13'(PROJ_H) >= cell_y);
    end
  endgenerate

  always_comb begin
    win         = '0;
    any_overlap = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (overlap[i] && !any_overlap) begin
        win[i]      = 1'b1;
        any_overlap = 1'b1;
      end
    end
  end

  assign kill = any_overlap && alive_reg[row_reg][col_reg];

  // Lowest (highest-index) row that still has a live invader.
  always_comb begin
    low_found = 1'b0;
    low_row   = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (|alive_reg[r]) begin
        low_found = 1'b1;
        low_row   = RW'(r);
      end
    end
  end

  assign bottom_y = 13'(ey_reg) + 13'(low_row) * 13'(ROW_PITCH) + 13'(INV_H);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_start && !revive) state_next = SCAN;
      SCAN:    if (last_cell) state_next = CHECK;
      CHECK:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alive_reg      <= '1;
      px_reg         <= '0;
      py_reg         <= '0;
      act_reg        <= '0;
      hit_reg        <= '0;
      ix_reg         <= '0;
      ey_reg         <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      score_reg      <= '0;
      kill_reg       <= '0;
      player_hit_reg <= 1'b0;
      all_dead_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (revive) begin
            alive_reg      <= '1;
            player_hit_reg <= 1'b0;
            all_dead_reg   <= 1'b0;
          end else if (frame_start) begin
            px_reg    <= proj_x;
            py_reg    <= proj_y;
            act_reg   <= bullet_active;
            ix_reg    <= inv_x;
            ey_reg    <= enemy_ypos;
            hit_reg   <= '0;
            score_reg <= '0;
            kill_reg  <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
          end
        end
        SCAN: begin
          if (kill) begin
            alive_reg[row_reg][col_reg] <= 1'b0;
            kill_reg  <= kill_reg + 8'd1;
            score_reg <= score_reg + points;
            hit_reg   <= hit_reg | win;
          end
          if (col_reg == CW'(NUM_COLS - 1)) begin
            col_reg <= '0;
            row_reg <= row_reg + 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end
        CHECK: begin
          if (low_found && (bottom_y >= 13'(DEFEAT_Y))) player_hit_reg <= 1'b1;
          all_dead_reg <= (alive_reg == '0);
        end
        default: ;
      endcase
    end
  end

  assign alive       = alive_reg;
  assign busy        = (state_reg != IDLE);
  assign scan_done   = (state_reg == DONE);
  assign bullet_hit  = scan_done ? hit_reg : '0;
  assign frame_score = score_reg;
  assign kill_count  = kill_reg;
  assign player_hit  = player_hit_reg;
  assign all_dead    = all_dead_reg;

endmodule
